// File: rtl/clock_set_ctrl_pkg.sv
// Shared state encodings and counter sizing helper for the clock set controller.
package clock_set_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ST_NORMAL   = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    // Bits needed to hold a counter that runs 0 .. limit-1.
    function automatic int cnt_width(input int unsigned limit);
        if (limit <= 32'd2) begin
            return 1;
        end else begin
            return $clog2(limit);
        end
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Increment button: edge detect plus hold-to-repeat timing; emits a one-cycle
// combinational pulse that the parent registers.
module clock_set_ctrl_btn_repeat
    import clock_set_ctrl_pkg::*;
#(
    parameter logic [23:0] REPEAT_DLY  = 24'd500000,
    parameter logic [23:0] REPEAT_RATE = 24'd100000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int unsigned DLY_U  = 32'(REPEAT_DLY);
    localparam int unsigned RATE_U = 32'(REPEAT_RATE);
    localparam int CNT_W = cnt_width((DLY_U > RATE_U) ? DLY_U : RATE_U);
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(DLY_U - 32'd1);
    localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(RATE_U - 32'd1);

    logic             prev_r;
    logic             armed_r;
    logic             rate_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_s;
    logic             armed_s;
    logic             rate_s;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] lim_s;
    logic             pulse_s;

    // Repeat only runs after a press seen while enabled; clear or release disarms it.
    always_comb begin
        press_s = btn & ~prev_r;
        lim_s   = rate_r ? RATE_LIM : DLY_LIM;
        pulse_s = 1'b0;
        armed_s = armed_r;
        rate_s  = rate_r;
        cnt_s   = cnt_r;
        if (clr || !btn) begin
            armed_s = 1'b0;
            rate_s  = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
        end else if (press_s && en) begin
            pulse_s = 1'b1;
            armed_s = 1'b1;
            rate_s  = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
        end else if (armed_r && (cnt_r == lim_s)) begin
            pulse_s = 1'b1;
            rate_s  = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
        end else if (armed_r) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Edge register and repeat timer state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
            rate_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            prev_r  <= btn;
            armed_r <= armed_s;
            rate_r  <= rate_s;
            cnt_r   <= cnt_s;
        end
    end

    assign pulse = pulse_s;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode / time-set controller: gates the 1 Hz enable, issues hour/minute
// increment strobes, drives blink masks and an inactivity timeout.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter logic [23:0] REPEAT_DLY  = 24'd500000,
    parameter logic [23:0] REPEAT_RATE = 24'd100000,
    parameter logic [23:0] BLINK_HALF  = 24'd250000,
    parameter logic [27:0] TIMEOUT     = 28'd50000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN_MODE,
    input  logic              BTN_INC,
    input  logic              EN1HZ,
    output logic              SEC_EN,
    output logic              SEC_CLR,
    output logic              MIN_INC,
    output logic              HOUR_INC,
    output logic              BLINK_H,
    output logic              BLINK_M,
    output logic [MODE_W-1:0] MODE
);

    localparam int IDLE_W  = cnt_width(32'(TIMEOUT));
    localparam int BLINK_W = cnt_width(32'(BLINK_HALF));
    localparam logic [IDLE_W-1:0]  IDLE_LIM  = IDLE_W'(32'(TIMEOUT) - 32'd1);
    localparam logic [BLINK_W-1:0] BLINK_LIM = BLINK_W'(32'(BLINK_HALF) - 32'd1);

    state_t               state_r;
    state_t               state_s;
    logic                 mode_prev_r;
    logic                 mode_press_s;
    logic                 set_state_s;
    logic                 state_chg_s;
    logic                 timeout_s;
    logic                 inc_pulse_s;
    logic                 hour_inc_s;
    logic                 min_inc_s;
    logic                 sec_clr_s;
    logic                 hour_inc_r;
    logic                 min_inc_r;
    logic                 sec_clr_r;
    logic [IDLE_W-1:0]    idle_cnt_r;
    logic [BLINK_W-1:0]   blink_cnt_r;
    logic                 blink_off_r;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_NORMAL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a MODE press always takes priority over timeout.
    always_comb begin
        mode_press_s = BTN_MODE & ~mode_prev_r;
        timeout_s    = (idle_cnt_r == IDLE_LIM);
        state_s      = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (mode_press_s) begin
                    state_s = ST_SET_HOUR;
                end else begin
                    state_s = ST_NORMAL;
                end
            end
            ST_SET_HOUR: begin
                if (mode_press_s) begin
                    state_s = ST_SET_MIN;
                end else if (timeout_s) begin
                    state_s = ST_NORMAL;
                end else begin
                    state_s = ST_SET_HOUR;
                end
            end
            ST_SET_MIN: begin
                if (mode_press_s || timeout_s) begin
                    state_s = ST_NORMAL;
                end else begin
                    state_s = ST_SET_MIN;
                end
            end
            default: begin
                state_s = ST_NORMAL;
            end
        endcase
        state_chg_s = (state_s != state_r);
        set_state_s = (state_r == ST_SET_HOUR) || (state_r == ST_SET_MIN);
    end

    clock_set_ctrl_btn_repeat #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_inc (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (BTN_INC),
        .en    (set_state_s),
        .clr   (state_chg_s),
        .pulse (inc_pulse_s)
    );

    // Output logic; SEC_EN and blink masks follow their inputs with zero latency.
    always_comb begin
        hour_inc_s = inc_pulse_s & (state_r == ST_SET_HOUR);
        min_inc_s  = inc_pulse_s & (state_r == ST_SET_MIN);
        sec_clr_s  = mode_press_s & (state_r == ST_SET_MIN);
        SEC_EN     = EN1HZ & (state_r == ST_NORMAL);
        BLINK_H    = (state_r == ST_SET_HOUR) & blink_off_r & ~BTN_INC;
        BLINK_M    = (state_r == ST_SET_MIN) & blink_off_r & ~BTN_INC;
        MODE       = state_r;
        SEC_CLR    = sec_clr_r;
        HOUR_INC   = hour_inc_r;
        MIN_INC    = min_inc_r;
    end

    // Strobes, MODE edge register, inactivity and blink counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hour_inc_r  <= 1'b0;
            min_inc_r   <= 1'b0;
            sec_clr_r   <= 1'b0;
            mode_prev_r <= 1'b0;
            idle_cnt_r  <= {IDLE_W{1'b0}};
            blink_cnt_r <= {BLINK_W{1'b0}};
            blink_off_r <= 1'b0;
        end else begin
            hour_inc_r  <= hour_inc_s;
            min_inc_r   <= min_inc_s;
            sec_clr_r   <= sec_clr_s;
            mode_prev_r <= BTN_MODE;
            if (!set_state_s || state_chg_s || BTN_MODE || BTN_INC) begin
                idle_cnt_r <= {IDLE_W{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
            end
            // Every state entry restarts the blink with digits visible.
            if (state_chg_s) begin
                blink_cnt_r <= {BLINK_W{1'b0}};
                blink_off_r <= 1'b0;
            end else if (blink_cnt_r == BLINK_LIM) begin
                blink_cnt_r <= {BLINK_W{1'b0}};
                blink_off_r <= ~blink_off_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with small timing parameters.
module tb_clock_set_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic       en1hz;
    logic       sec_en;
    logic       sec_clr;
    logic       min_inc;
    logic       hour_inc;
    logic       blink_h;
    logic       blink_m;
    logic [1:0] mode;

    int n_cmp;
    int n_err;

    clock_set_ctrl #(
        .REPEAT_DLY  (24'd8),
        .REPEAT_RATE (24'd4),
        .BLINK_HALF  (24'd5),
        .TIMEOUT     (28'd40)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .BTN_MODE (btn_mode),
        .BTN_INC  (btn_inc),
        .EN1HZ    (en1hz),
        .SEC_EN   (sec_en),
        .SEC_CLR  (sec_clr),
        .MIN_INC  (min_inc),
        .HOUR_INC (hour_inc),
        .BLINK_H  (blink_h),
        .BLINK_M  (blink_m),
        .MODE     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after each rising edge; checks happen 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; en1hz = 1'b0;
        tick(); tick();
        #3;
        n_cmp++;
        if ({sec_en, sec_clr, min_inc, hour_inc, blink_h, blink_m, mode} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {sec_en, sec_clr, min_inc, hour_inc, blink_h, blink_m, mode});
        end
        tick();
        rst = 1'b0; en1hz = 1'b1;
        #3;
        n_cmp++;
        if ({sec_en, mode} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release_secen got=%b want=100", {sec_en, mode});
        end
        tick();
        en1hz = 1'b0;
        #3;
        n_cmp++;
        if (sec_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_secen_low got=%b want=0", sec_en);
        end
        tick();
    endtask

    task automatic test_normal();
        int pulses;
        logic exp_en;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            exp_en = (k == 1 || k == 4 || k == 7);
            en1hz = exp_en;
            btn_inc = (k == 2 || k == 3);
            #3;
            if (sec_en === 1'b1) pulses++;
            n_cmp++;
            if ({sec_en, hour_inc, min_inc, mode} !== {exp_en, 1'b0, 1'b0, 2'd0}) begin
                n_err++;
                $display("FAIL normal_cycle%0d got=%b want=%b", k,
                         {sec_en, hour_inc, min_inc, mode}, {exp_en, 4'b0000});
            end
            tick();
        end
        en1hz = 1'b0; btn_inc = 1'b0;
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL normal_pulse_count got=%0d want=3", pulses);
        end
    endtask

    task automatic test_mode_seq();
        logic [1:0] exp_mode;
        logic       exp_clr;
        for (int k = 0; k < 10; k++) begin
            btn_mode = (k == 0 || k == 2 || k == 4);
            case (k)
                1, 2:    exp_mode = 2'd1;
                3, 4:    exp_mode = 2'd2;
                default: exp_mode = 2'd0;
            endcase
            exp_clr = (k == 5);
            #3;
            n_cmp++;
            if ({mode, sec_clr, hour_inc, min_inc} !== {exp_mode, exp_clr, 2'b00}) begin
                n_err++;
                $display("FAIL mode_seq_cycle%0d got=%b want=%b", k,
                         {mode, sec_clr, hour_inc, min_inc}, {exp_mode, exp_clr, 2'b00});
            end
            tick();
        end
        btn_mode = 1'b0;
    endtask

    task automatic test_hour_repeat();
        logic exp_inc;
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        #3;
        n_cmp++;
        if (mode !== 2'd1) begin
            n_err++;
            $display("FAIL hour_enter got=%0d want=1", mode);
        end
        tick();
        for (int k = 0; k < 22; k++) begin
            btn_inc = (k < 20);
            en1hz = (k % 3 == 0);
            exp_inc = (k == 1 || k == 9 || k == 13 || k == 17);
            #3;
            n_cmp++;
            if ({mode, hour_inc, min_inc, sec_en, sec_clr} !== {2'd1, exp_inc, 3'b000}) begin
                n_err++;
                $display("FAIL hour_repeat_cycle%0d got=%b want=%b", k,
                         {mode, hour_inc, min_inc, sec_en, sec_clr}, {2'd1, exp_inc, 3'b000});
            end
            if (k < 20) begin
                n_cmp++;
                if (blink_h !== 1'b0) begin
                    n_err++;
                    $display("FAIL hour_blink_held_cycle%0d got=%b want=0", k, blink_h);
                end
            end
            tick();
        end
        btn_inc = 1'b0; en1hz = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_mode;
        for (int k = 0; k < 13; k++) begin
            btn_mode = (k == 0);
            btn_inc = (k <= 10);
            exp_mode = (k == 0) ? 2'd1 : 2'd2;
            #3;
            n_cmp++;
            if ({mode, hour_inc, min_inc} !== {exp_mode, 2'b00}) begin
                n_err++;
                $display("FAIL simul_cycle%0d got=%b want=%b", k,
                         {mode, hour_inc, min_inc}, {exp_mode, 2'b00});
            end
            if (k >= 1 && k <= 10) begin
                n_cmp++;
                if (blink_m !== 1'b0) begin
                    n_err++;
                    $display("FAIL simul_blink_held_cycle%0d got=%b want=0", k, blink_m);
                end
            end
            tick();
        end
        btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic test_timeout_blink();
        logic       exp_blink;
        logic [1:0] exp_mode;
        // SET_MIN -> NORMAL -> SET_HOUR -> SET_MIN
        for (int k = 0; k < 5; k++) begin
            btn_mode = (k % 2 == 0);
            #3;
            if (k == 1) begin
                n_cmp++;
                if ({mode, sec_clr} !== 3'b001) begin
                    n_err++;
                    $display("FAIL exit_min_clr got=%b want=001", {mode, sec_clr});
                end
            end
            tick();
        end
        btn_mode = 1'b0;
        for (int t = 0; t < 43; t++) begin
            exp_mode  = (t < 40) ? 2'd2 : 2'd0;
            exp_blink = (t < 40) && (((t / 5) % 2) == 1);
            #3;
            n_cmp++;
            if ({mode, blink_m, blink_h, sec_clr} !== {exp_mode, exp_blink, 2'b00}) begin
                n_err++;
                $display("FAIL timeout_cycle%0d got=%b want=%b", t,
                         {mode, blink_m, blink_h, sec_clr}, {exp_mode, exp_blink, 2'b00});
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b1;
        tick();
        n_cmp++;
        if ({mode, hour_inc} !== 3'b011) begin
            n_err++;
            $display("FAIL pre_reset_strobe got=%b want=011", {mode, hour_inc});
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sec_en, sec_clr, min_inc, hour_inc, blink_h, blink_m, mode} !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset got=%b want=00000000",
                     {sec_en, sec_clr, min_inc, hour_inc, blink_h, blink_m, mode});
        end
        tick(); tick();
        rst = 1'b0; en1hz = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            n_cmp++;
            if ({sec_en, mode, hour_inc, min_inc} !== {en1hz, 4'b0000}) begin
                n_err++;
                $display("FAIL post_reset_cycle%0d got=%b want=%b", k,
                         {sec_en, mode, hour_inc, min_inc}, {en1hz, 4'b0000});
            end
            tick();
            en1hz = (k == 1);
        end
        btn_inc = 1'b0; en1hz = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_normal();
        test_mode_seq();
        test_hour_repeat();
        test_simultaneous();
        test_timeout_blink();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode and time-set controller for the 24-hour clock. Sits between the debounced front-panel buttons and the hour/minute/second counter chain. In normal mode it passes the 1 Hz enable through to the seconds counter. In set modes it freezes the seconds, issues single or auto-repeat increment strobes to the hour or minute counter, and drives the display blink masks.

Parameters:
REPEAT_DLY, 24'd500000, CLK cycles INC must be held after its press pulse before auto-repeat starts.
REPEAT_RATE, 24'd100000, CLK cycles between auto-repeat pulses.
BLINK_HALF, 24'd250000, CLK cycles per blink half-period.
TIMEOUT, 28'd50000000, CLK cycles without any button activity in a set mode before forced return to NORMAL.

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
BTN_MODE  in  1  debounced, synchronised mode button level, 1 = pressed
BTN_INC  in  1  debounced, synchronised increment button level
EN1HZ  in  1  one-CLK pulse per second from prescaler
SEC_EN  out  1  enable to seconds counter
SEC_CLR  out  1  one-cycle clear to seconds counter
MIN_INC  out  1  one-cycle increment to minute counter
HOUR_INC  out  1  one-cycle increment to hour counter
BLINK_H  out  1  1 = blank hour digits this cycle
BLINK_M  out  1  1 = blank minute digits this cycle
MODE  out  2  current state encoding

Behaviour:
- Reset (async, RST=1): state NORMAL; all strobes 0; blink outputs 0; MODE=2'd0; all internal counters and edge registers cleared. Edge registers clear to 0, so a button held through reset produces an edge on the first cycle after release of RST.
- States and encoding: NORMAL=0, SET_HOUR=1, SET_MIN=2. Encoding 3 is illegal and recovers to NORMAL on the next cycle.
- Edge detect: a button is pressed on the cycle its level is 1 and the registered previous level is 0.
- MODE press: NORMAL->SET_HOUR; SET_HOUR->SET_MIN; SET_MIN->NORMAL with SEC_CLR=1 for exactly that transition cycle.
- SEC_EN: equals EN1HZ when state is NORMAL (combinational pass-through, zero latency). Forced 0 in set states.
- INC in NORMAL: ignored; no strobes.
- INC press in a set state: one-cycle strobe (HOUR_INC in SET_HOUR, MIN_INC in SET_MIN), registered, asserted the cycle after the edge. The repeat counter loads 0.
  - While held, the first repeat strobe fires REPEAT_DLY cycles after the press strobe, then one every REPEAT_RATE cycles.
  - Releasing INC stops repeats immediately; the counter resets.
- Simultaneous MODE and INC press: MODE wins, the INC edge is discarded, and the repeat counter resets. Repeat never carries across a state change, even if INC stays held.
- At most one of HOUR_INC/MIN_INC/SEC_CLR is high in any cycle.
- Blink:
  - The phase counter resets on every state entry with phase ON (digits visible).
  - Phase toggles every BLINK_HALF cycles.
  - BLINK_H = (state==SET_HOUR) & phase OFF & ~BTN_INC.
  - BLINK_M = (state==SET_MIN) & phase OFF & ~BTN_INC. Digits stay visible while INC is held.
  - Both are 0 in NORMAL.
- Timeout:
  - The inactivity counter runs only in set states and resets on any MODE or INC level=1.
  - Reaching TIMEOUT-1 forces NORMAL next cycle without SEC_CLR. The seconds counter resumes from its frozen value.
- Counter widths are sized from the parameters; all counters saturate-free, compare-and-reload only.

Decomposition:
- Shared package/include holds the state encodings (ST_NORMAL, ST_SET_HOUR, ST_SET_MIN) and the MODE width, for display and top-level use.
- One sub-module is natural: btn_repeat. It contains the edge detect, the REPEAT_DLY/REPEAT_RATE counter, and a clear input driven on state change, and it outputs a single-cycle pulse.
- The blink divider stays inline.

Test Plan:
1. Run with params REPEAT_DLY=8, REPEAT_RATE=4, BLINK_HALF=5, TIMEOUT=40. Assert RST mid-run with INC held -> all outputs 0 immediately (async), MODE=0; after release, SEC_EN follows EN1HZ.
2. In NORMAL, give 3 EN1HZ pulses and one INC press -> SEC_EN pulses 3 times aligned with EN1HZ; no HOUR_INC/MIN_INC.
3. MODE press, then hold INC 20 cycles -> MODE=1; HOUR_INC at edge+1, edge+9, edge+13, edge+17 (4 pulses); BLINK_H=0 while held; SEC_EN=0 despite EN1HZ.
4. MODE, MODE, MODE presses from NORMAL -> MODE 1,2,0; SEC_CLR=1 for exactly one cycle on the 2->0 transition, never otherwise.
5. MODE and INC rising in the same cycle from SET_HOUR -> MODE=2, no HOUR_INC or MIN_INC. INC stays held 10 cycles -> no MIN_INC (repeat cleared).
6. Enter SET_MIN and stay idle -> BLINK_M toggles every 5 cycles, starting visible; at cycle 40 MODE returns to 0 with SEC_CLR=0.
